// File: rtl/alu_result_writeback_if.sv
// alu_result_writeback_if: capture and bus handshake signals for the ALU result writeback block
//   C, op, cap_valid, cap_ready   : result capture from the ALU (valid/ready)
//   bus_out, bus_valid, bus_ready : word beats toward the datapath bus (valid/ready)
//   bus_hi                        : 0 = ZLow beat, 1 = ZHigh beat
interface alu_result_writeback_if #(parameter int WIDTH = 32);
   logic [2*WIDTH-1:0] C;
   logic [3:0]         op;
   logic               cap_valid;
   logic               cap_ready;
   logic [WIDTH-1:0]   bus_out;
   logic               bus_valid;
   logic               bus_ready;
   logic               bus_hi;
   modport master (output C, op, cap_valid, bus_ready, input cap_ready, bus_out, bus_valid, bus_hi);
   modport slave  (input C, op, cap_valid, bus_ready, output cap_ready, bus_out, bus_valid, bus_hi);
endinterface

// File: rtl/alu_result_writeback.sv
// alu_result_writeback: captures the 64-bit ALU result, holds Z/HI/LO and returns it to the bus in one or two beats
//   clock, clear_n   : rising-edge clock, asynchronous active-low reset
//   io (slave)       : capture handshake (C, op) and bus beat handshake
//   hi_reg, lo_reg   : HI/LO words of the last MUL/DIV result
//   flag_z, flag_n   : zero/negative of the last captured result
//   busy             : a result is still being returned
module alu_result_writeback #(
   parameter int         WIDTH  = 32,
   parameter logic [3:0] MUL_OP = 4'b0110,
   parameter logic [3:0] DIV_OP = 4'b0111
) (
   input  logic                       clock,
   input  logic                       clear_n,
   alu_result_writeback_if.slave      io,
   output logic [WIDTH-1:0]           hi_reg,
   output logic [WIDTH-1:0]           lo_reg,
   output logic                       flag_z,
   output logic                       flag_n,
   output logic                       busy
);
   typedef enum logic [1:0] {IDLE, SEND_LO, SEND_HI} state_t;
   state_t             state, next_state;
   logic [2*WIDTH-1:0] z;
   logic               wide;
   logic               capture;
   logic               op_wide;
   assign capture = io.cap_valid && (state == IDLE);
   assign op_wide = (io.op == MUL_OP) || (io.op == DIV_OP);
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    next_state = io.cap_valid ? SEND_LO : IDLE;
         SEND_LO: next_state = io.bus_ready ? (wide ? SEND_HI : IDLE) : SEND_LO;
         SEND_HI: next_state = io.bus_ready ? IDLE : SEND_HI;
         default: next_state = IDLE;
      endcase
   end
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         state  <= IDLE;
         z      <= '0;
         wide   <= 1'b0;
         hi_reg <= '0;
         lo_reg <= '0;
         flag_z <= 1'b0;
         flag_n <= 1'b0;
      end else begin
         state <= next_state;
         if (capture) begin
            z    <= io.C;
            wide <= op_wide;
            if (op_wide) begin
               hi_reg <= io.C[2*WIDTH-1:WIDTH];
               lo_reg <= io.C[WIDTH-1:0];
            end
            // narrow ops judge only the low word; the upper half of C is don't-care
            flag_z <= op_wide ? (io.C == '0) : (io.C[WIDTH-1:0] == '0);
            flag_n <= op_wide ? io.C[2*WIDTH-1] : io.C[WIDTH-1];
         end
      end
   end
   // bus side is decoded from state and Z only, so C/op never reach bus_out combinationally
   assign io.cap_ready = (state == IDLE);
   assign io.bus_valid = (state != IDLE);
   assign io.bus_hi    = (state == SEND_HI);
   assign io.bus_out   = (state == SEND_LO) ? z[WIDTH-1:0] :
                         (state == SEND_HI) ? z[2*WIDTH-1:WIDTH] : '0;
   assign busy         = (state != IDLE);
endmodule

// File: doc/alu_result_writeback.md
Name: alu_result_writeback

Overview:
- Sits on the output side of the 32-bit ALU and captures its 64-bit result C together with the opcode that produced it.
- Holds the result in the Z register and the HI/LO architectural registers.
- Returns the result to the 32-bit datapath bus as one beat (single-width ops) or two beats (MUL/DIV: ZLow, then ZHigh).
- Uses a valid/ready handshake on both the capture side and the bus side, and publishes zero/negative condition flags.

Parameters:
- WIDTH, 32, datapath word width; the result is 2*WIDTH.
- MUL_OP, 4'b0110, opcode whose result is two words wide.
- DIV_OP, 4'b0111, opcode whose result is two words wide (quotient/remainder pair).

Ports:
- clock  in  1  rising-edge system clock.
- clear_n  in  1  reset, asynchronous, active-low.
- C  in  2*WIDTH  ALU result.
- op  in  4  ALU opcode that produced C.
- cap_valid  in  1  C/op are valid this cycle.
- cap_ready  out  1  block can accept a result.
- bus_out  out  WIDTH  word driven toward the bus mux.
- bus_valid  out  1  bus_out holds a valid beat.
- bus_ready  in  1  bus consumer accepts the beat.
- bus_hi  out  1  0 = current beat is ZLow, 1 = current beat is ZHigh.
- hi_reg  out  WIDTH  HI register (upper word of the last MUL/DIV).
- lo_reg  out  WIDTH  LO register (lower word of the last MUL/DIV).
- flag_z  out  1  last captured result is zero.
- flag_n  out  1  last captured result is negative.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset (clear_n low, asynchronous):
  - state=IDLE.
  - Z register, hi_reg, lo_reg, bus_out, flag_z, flag_n = 0.
  - bus_valid=0, bus_hi=0, busy=0.
  - cap_ready=1 immediately after release.
- State machine: IDLE, SEND_LO, SEND_HI. All outputs are registered or decoded from state only, with no combinational path from C/op to bus_out.
- cap_ready = (state==IDLE). A capture occurs when cap_valid && cap_ready at a rising edge.
- On capture:
  - Z <= C; a wide-op bit is latched (op==MUL_OP or op==DIV_OP).
  - Wide op: hi_reg <= C[2W-1:W], lo_reg <= C[W-1:0]. Otherwise hi_reg and lo_reg are unchanged.
  - Wide op: flag_z = (C[2W-1:0]==0), flag_n = C[2W-1].
  - Narrow op: flag_z = (C[W-1:0]==0), flag_n = C[W-1]. Upper bits of C are ignored.
  - Next state is SEND_LO.
- SEND_LO:
  - bus_valid=1, bus_out=Z[W-1:0], bus_hi=0.
  - On bus_ready: wide op goes to SEND_HI; narrow op goes to IDLE.
- SEND_HI:
  - bus_valid=1, bus_out=Z[2W-1:W], bus_hi=1.
  - On bus_ready goes to IDLE.
- Latency:
  - First beat is valid the cycle after capture.
  - Capture-to-idle is 1+beats cycles under constant bus_ready=1.
  - After the last beat is accepted, cap_ready rises the next cycle, so there is a minimum one-cycle bubble between results.
- Backpressure: while bus_valid && !bus_ready, bus_out, bus_hi and state are held stable for an unbounded number of cycles. Inputs C/op may change freely and are ignored outside the capture cycle.
- cap_valid while not IDLE is ignored; the producer must hold cap_valid until cap_ready.
- An opcode outside 0..12 is treated as narrow.
- Flags persist until the next capture; they are not cleared on return to IDLE.
- Reset mid-transfer: pending beats are discarded, bus_valid drops asynchronously, and hi_reg/lo_reg return to 0.

Test Plan:
- AND result, narrow op: op=4'b0000, C=64'hDEAD_BEEF_0000_00F0, bus_ready=1.
  - Exactly one beat, bus_out=32'h000000F0, bus_hi=0.
  - flag_z=0, flag_n=0; hi_reg/lo_reg unchanged at 0.
  - cap_ready returns high 2 cycles after capture.
- MUL result, wide op: op=MUL_OP, C=64'hFFFF_FFFF_8000_0001.
  - Beats are 32'h80000001 (bus_hi=0), then 32'hFFFFFFFF (bus_hi=1).
  - hi_reg=32'hFFFFFFFF, lo_reg=32'h80000001, flag_n=1, flag_z=0.
- Backpressure on DIV result: op=DIV_OP, C=64'h0000_0003_0000_0007, bus_ready low for 5 cycles in SEND_LO.
  - bus_out is held at 32'h00000007 and bus_valid stays 1 throughout.
  - After bus_ready rises, the second beat is 32'h00000003.
- Zero detection on a wide op: op=MUL_OP, C=0.
  - flag_z=1 and two beats of 0.
  - Then op=OR, C=64'h1_0000_0000: flag_z=1, because the upper word is ignored for narrow ops.
- Capture during busy and reset mid-transfer:
  - Assert cap_valid with C=64'h55 while in SEND_HI: it is not captured.
  - Assert clear_n=0 mid SEND_HI: bus_valid=0 and hi_reg=lo_reg=0 without waiting for a clock edge, then state is IDLE and cap_ready=1 after release.
